// File: rtl/axi_wr_dispatch_if.sv
// Bus bundle between a write-beat source/target environment and axi_wr_dispatch.
// The master modport is the environment side; the slave modport is the dispatcher.
interface axi_wr_dispatch_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64
);
    logic                  axi_wr_vld;
    logic [ADDR_WIDTH-1:0] axi_wr_addr;
    logic [DATA_WIDTH-1:0] axi_wr_data;
    logic [DATA_WIDTH-1:0] axi_wr_strb;
    logic [1:0]            axi_wr_region;

    logic                  fifo_wr_done;
    logic                  iram_wr_done;
    logic                  wram_wr_done;
    logic                  fifo_err;

    logic                  fifo_push;
    logic [DATA_WIDTH-1:0] fifo_wdata;
    logic                  fifo_full;

    logic                  iram_we;
    logic [ADDR_WIDTH-1:0] iram_addr;
    logic [DATA_WIDTH-1:0] iram_wdata;
    logic [DATA_WIDTH-1:0] iram_wmask;

    logic                  wram_we;
    logic [ADDR_WIDTH-1:0] wram_addr;
    logic [DATA_WIDTH-1:0] wram_wdata;
    logic [DATA_WIDTH-1:0] wram_wmask;

    logic                  dispatch_busy;
    logic                  drop_err;

    modport master (
        output axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region, fifo_full,
        input  fifo_wr_done, iram_wr_done, wram_wr_done, fifo_err,
        input  fifo_push, fifo_wdata,
        input  iram_we, iram_addr, iram_wdata, iram_wmask,
        input  wram_we, wram_addr, wram_wdata, wram_wmask,
        input  dispatch_busy, drop_err
    );

    modport slave (
        input  axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region, fifo_full,
        output fifo_wr_done, iram_wr_done, wram_wr_done, fifo_err,
        output fifo_push, fifo_wdata,
        output iram_we, iram_addr, iram_wdata, iram_wmask,
        output wram_we, wram_addr, wram_wdata, wram_wmask,
        output dispatch_busy, drop_err
    );
endinterface

// File: rtl/axi_wr_dispatch.sv
// Single-beat write dispatcher: routes a captured beat to the FIFO, IRAM or WRAM port.
// Optional FIFO-full wait timeout is enabled by defining WR_DISPATCH_TIMEOUT_EN.
module axi_wr_dispatch #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    axi_wr_dispatch_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        FIFO_WAIT = 2'd2,
        DONE      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REG_FIFO    = 2'd0,
        REG_IRAM    = 2'd1,
        REG_WRAM    = 2'd2,
        REG_INVALID = 2'd3
    } region_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("axi_wr_dispatch: TIMEOUT_CYCLES must be within 1..255");
    end

    state_t                state;
    region_t               hold_region;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] hold_strb;
    logic                  err_flag;
    logic                  drop_err_q;

`ifdef WR_DISPATCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`endif

    logic full_mask;
    logic push_now;

    assign full_mask = (hold_strb == {DATA_WIDTH{1'b1}});

    // NOTE: strobes are decoded from registered state, not registered themselves, so
    // the FIFO push can be qualified by fifo_full in the very cycle it is issued.
    assign push_now = ((state == ISSUE) || (state == FIFO_WAIT)) &&
                      (hold_region == REG_FIFO) && full_mask && !bus.fifo_full;

    assign bus.fifo_push     = push_now;
    assign bus.iram_we       = (state == ISSUE) && (hold_region == REG_IRAM);
    assign bus.wram_we       = (state == ISSUE) && (hold_region == REG_WRAM);

    assign bus.fifo_wr_done  = (state == DONE) &&
                               ((hold_region == REG_FIFO) || (hold_region == REG_INVALID));
    assign bus.iram_wr_done  = (state == DONE) && (hold_region == REG_IRAM);
    assign bus.wram_wr_done  = (state == DONE) && (hold_region == REG_WRAM);
    assign bus.fifo_err      = (state == DONE) && err_flag;

    assign bus.dispatch_busy = (state != IDLE);
    assign bus.drop_err      = drop_err_q;

    assign bus.fifo_wdata    = hold_data;
    assign bus.iram_addr     = hold_addr;
    assign bus.iram_wdata    = hold_data;
    assign bus.iram_wmask    = hold_strb;
    assign bus.wram_addr     = hold_addr;
    assign bus.wram_wdata    = hold_data;
    assign bus.wram_wmask    = hold_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: holding registers are reset too, so the always-driven address and
            // data outputs read as zero while reset is asserted.
            state       <= IDLE;
            hold_region <= REG_FIFO;
            hold_addr   <= '0;
            hold_data   <= '0;
            hold_strb   <= '0;
            err_flag    <= 1'b0;
            drop_err_q  <= 1'b0;
`ifdef WR_DISPATCH_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            if (bus.axi_wr_vld && (state != IDLE)) begin
                drop_err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.axi_wr_vld) begin
                        hold_region <= region_t'(bus.axi_wr_region);
                        hold_addr   <= bus.axi_wr_addr;
                        hold_data   <= bus.axi_wr_data;
                        hold_strb   <= bus.axi_wr_strb;
                        err_flag    <= 1'b0;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    case (hold_region)
                        REG_IRAM, REG_WRAM: begin
                            state <= DONE;
                        end
                        REG_FIFO: begin
                            // A partial mask cannot be expressed as a FIFO push.
                            if (!full_mask) begin
                                err_flag <= 1'b1;
                                state    <= DONE;
                            end else if (!bus.fifo_full) begin
                                state <= DONE;
                            end else begin
`ifdef WR_DISPATCH_TIMEOUT_EN
                                wait_cnt <= '0;
`endif
                                state    <= FIFO_WAIT;
                            end
                        end
                        default: begin
                            err_flag <= 1'b1;
                            state    <= DONE;
                        end
                    endcase
                end

                FIFO_WAIT: begin
                    if (!bus.fifo_full) begin
                        state <= DONE;
`ifdef WR_DISPATCH_TIMEOUT_EN
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        err_flag <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
`endif
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_dispatch.sv
// Randomized self-checking bench for axi_wr_dispatch against a per-beat outcome model.
// Define WR_DISPATCH_TIMEOUT_EN for both bench and RTL to exercise the timeout build.
module tb_axi_wr_dispatch;

    localparam int AW = 11;
    localparam int DW = 64;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_wr_dispatch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_wr_dispatch #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Outcome of one beat: kinds are 0 none, 1 fifo, 2 iram, 3 wram; offsets are
    // cycles after the cycle carrying axi_wr_vld.
    typedef struct packed {
        int            strobe_kind;
        int            n_strobe;
        int            strobe_off;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        int            done_kind;
        int            n_done;
        int            done_off;
        logic          err;
        int            n_overlap;
    } beat_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit drop_model = 1'b0;

    function automatic beat_t predict(input logic [1:0] region, input logic [AW-1:0] addr,
                                      input logic [DW-1:0] data, input logic [DW-1:0] strb,
                                      input int full_cycles);
        beat_t e;
        bit    bad;
        bit    timeout;
        e       = '0;
        bad     = (region == 2'd3) || (region == 2'd0 && strb != {DW{1'b1}});
        timeout = 1'b0;
`ifdef WR_DISPATCH_TIMEOUT_EN
        timeout = (full_cycles > TO);
`endif
        if (bad) begin
            e.done_kind = 1; e.n_done = 1; e.done_off = 2; e.err = 1'b1;
        end else if (region != 2'd0) begin
            e.strobe_kind = int'(region) + 1; e.n_strobe = 1; e.strobe_off = 1;
            e.addr = addr; e.data = data; e.mask = strb;
            e.done_kind = int'(region) + 1; e.n_done = 1; e.done_off = 2;
        end else if (timeout) begin
            e.done_kind = 1; e.n_done = 1; e.done_off = TO + 2; e.err = 1'b1;
        end else begin
            e.strobe_kind = 1; e.n_strobe = 1; e.strobe_off = 1 + full_cycles;
            e.data = data;
            e.done_kind = 1; e.n_done = 1; e.done_off = 2 + full_cycles;
        end
        return e;
    endfunction

    function automatic string fmt(input beat_t b);
        return $sformatf("strobe=%0d x%0d @%0d addr=%h data=%h mask=%h done=%0d x%0d @%0d err=%0b ovl=%0d",
                         b.strobe_kind, b.n_strobe, b.strobe_off, b.addr, b.data, b.mask,
                         b.done_kind, b.n_done, b.done_off, b.err, b.n_overlap);
    endfunction

    // Drives one beat, holds fifo_full high for offsets 1..full_cycles and records
    // every strobe and done pulse seen until one cycle past the done pulse.
    task automatic run_beat(input logic [1:0] region, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [DW-1:0] strb,
                            input int full_cycles, input bit second_vld, input int max_cycles,
                            output beat_t o, output bit timed_out);
        logic [2:0] s;
        logic [2:0] d;
        o         = '0;
        timed_out = 1'b1;
        @(posedge clk); #1;
        bus.axi_wr_vld    = 1'b1;
        bus.axi_wr_region = region;
        bus.axi_wr_addr   = addr;
        bus.axi_wr_data   = data;
        bus.axi_wr_strb   = strb;
        bus.fifo_full     = 1'b0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(posedge clk); #1;
            bus.axi_wr_vld = (k == 1) && second_vld;
            if (k == 1 && second_vld) begin
                bus.axi_wr_region = 2'($urandom_range(3));
                bus.axi_wr_addr   = AW'($urandom);
                bus.axi_wr_data   = {$urandom, $urandom};
                bus.axi_wr_strb   = {$urandom, $urandom};
            end
            bus.fifo_full = (k <= full_cycles);
            @(negedge clk);
            s = {bus.fifo_push, bus.iram_we, bus.wram_we};
            d = {bus.fifo_wr_done, bus.iram_wr_done, bus.wram_wr_done};
            if ($countones(s) > 1 || $countones(d) > 1) o.n_overlap++;
            if (bus.fifo_push) begin
                o.n_strobe++; o.strobe_kind = 1; o.strobe_off = k; o.data = bus.fifo_wdata;
            end
            if (bus.iram_we) begin
                o.n_strobe++; o.strobe_kind = 2; o.strobe_off = k;
                o.addr = bus.iram_addr; o.data = bus.iram_wdata; o.mask = bus.iram_wmask;
            end
            if (bus.wram_we) begin
                o.n_strobe++; o.strobe_kind = 3; o.strobe_off = k;
                o.addr = bus.wram_addr; o.data = bus.wram_wdata; o.mask = bus.wram_wmask;
            end
            if (d != 3'b000) begin
                o.n_done++; o.done_off = k; o.err = bus.fifo_err;
                o.done_kind = bus.fifo_wr_done ? 1 : (bus.iram_wr_done ? 2 : 3);
            end
            if (o.n_done != 0 && k >= o.done_off + 1) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.axi_wr_vld = 1'b0;
        bus.fifo_full  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n             = 1'b0;
        bus.axi_wr_vld    = 1'b0;
        bus.axi_wr_addr   = '0;
        bus.axi_wr_data   = '0;
        bus.axi_wr_strb   = '0;
        bus.axi_wr_region = '0;
        bus.fifo_full     = 1'b0;
        #3;
        n_cmp++;
        if ({bus.fifo_push, bus.iram_we, bus.wram_we, bus.fifo_wr_done, bus.iram_wr_done,
             bus.wram_wr_done, bus.fifo_err, bus.dispatch_busy, bus.drop_err} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 000000000",
                     {bus.fifo_push, bus.iram_we, bus.wram_we, bus.fifo_wr_done, bus.iram_wr_done,
                      bus.wram_wr_done, bus.fifo_err, bus.dispatch_busy, bus.drop_err});
        end
        n_cmp++;
        if ({bus.iram_addr, bus.iram_wdata, bus.iram_wmask, bus.wram_addr, bus.wram_wdata,
             bus.wram_wmask, bus.fifo_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: iram_addr=%h iram_wdata=%h fifo_wdata=%h required all zero",
                     bus.iram_addr, bus.iram_wdata, bus.fifo_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.dispatch_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b required 0", bus.dispatch_busy);
        end
    endtask

    task automatic test_iram();
        beat_t o, e;
        bit    to;
        run_beat(2'd1, 11'h010, {8{8'hA5}}, {DW{1'b1}}, 0, 1'b0, 20, o, to);
        e = predict(2'd1, 11'h010, {8{8'hA5}}, {DW{1'b1}}, 0);
        n_cmp++;
        if (to || o !== e) begin
            n_bad++;
            $display("FAIL iram_beat: got %s | required %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_fifo_backpressure();
        beat_t      o, e;
        bit         to;
        logic [DW-1:0] data;
        for (int fc = 0; fc <= 3; fc += 3) begin
            data = {$urandom, $urandom};
            run_beat(2'd0, AW'($urandom), data, {DW{1'b1}}, fc, 1'b0, 40, o, to);
            e = predict(2'd0, '0, data, {DW{1'b1}}, fc);
            n_cmp++;
            if (to || o !== e) begin
                n_bad++;
                $display("FAIL fifo_full_%0d: got %s | required %s", fc, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_errors();
        beat_t o, e;
        bit    to;
        logic [DW-1:0] partial;
        partial = 64'h00FF_FFFF_FFFF_FFFF;
        run_beat(2'd3, 11'h123, 64'h1234_5678_9ABC_DEF0, {DW{1'b1}}, 0, 1'b0, 20, o, to);
        e = predict(2'd3, 11'h123, 64'h1234_5678_9ABC_DEF0, {DW{1'b1}}, 0);
        n_cmp++;
        if (to || o !== e) begin
            n_bad++;
            $display("FAIL region3_err: got %s | required %s", fmt(o), fmt(e));
        end
        run_beat(2'd0, 11'h045, 64'hCAFE_F00D_0000_FFFF, partial, 2, 1'b0, 20, o, to);
        e = predict(2'd0, 11'h045, 64'hCAFE_F00D_0000_FFFF, partial, 2);
        n_cmp++;
        if (to || o !== e) begin
            n_bad++;
            $display("FAIL partial_mask_err: got %s | required %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_drop();
        beat_t o, e;
        bit    to;
        logic [DW-1:0] data;
        data = {$urandom, $urandom};
        run_beat(2'd1, 11'h3F0, data, {DW{1'b1}}, 0, 1'b1, 20, o, to);
        drop_model = 1'b1;
        e = predict(2'd1, 11'h3F0, data, {DW{1'b1}}, 0);
        n_cmp++;
        if (to || o !== e) begin
            n_bad++;
            $display("FAIL drop_first_beat: got %s | required %s", fmt(o), fmt(e));
        end
        n_cmp++;
        if (bus.drop_err !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_err_set: got %b required 1", bus.drop_err);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (bus.drop_err !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_err_sticky: got %b required 1", bus.drop_err);
        end
    endtask

    task automatic test_long_wait();
        beat_t o, e;
        bit    to;
        logic [DW-1:0] data;
        data = {$urandom, $urandom};
        run_beat(2'd0, 11'h0AA, data, {DW{1'b1}}, 300, 1'b0, 320, o, to);
        e = predict(2'd0, '0, data, {DW{1'b1}}, 300);
        n_cmp++;
        if (to || o !== e) begin
            n_bad++;
            $display("FAIL long_wait: got %s | required %s", fmt(o), fmt(e));
        end
`ifdef WR_DISPATCH_TIMEOUT_EN
        n_cmp++;
        if (o.n_strobe != 0 || o.done_off != TO + 2 || o.err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_abandon: pushes=%0d done_off=%0d err=%b required 0/%0d/1",
                     o.n_strobe, o.done_off, o.err, TO + 2);
        end
`else
        n_cmp++;
        if (o.strobe_off != 301 || o.err !== 1'b0) begin
            n_bad++;
            $display("FAIL indefinite_wait: push_off=%0d err=%b required 301/0", o.strobe_off, o.err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        beat_t o, e;
        bit    to;
        bit    seen;
        logic [DW-1:0] data;
        @(posedge clk); #1;
        bus.axi_wr_vld    = 1'b1;
        bus.axi_wr_region = 2'd0;
        bus.axi_wr_data   = {$urandom, $urandom};
        bus.axi_wr_strb   = {DW{1'b1}};
        @(posedge clk); #1;
        bus.axi_wr_vld = 1'b0;
        bus.fifo_full  = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.dispatch_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_in_wait: got %b required 1", bus.dispatch_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.fifo_push, bus.iram_we, bus.wram_we, bus.fifo_wr_done, bus.iram_wr_done,
             bus.wram_wr_done, bus.fifo_err, bus.dispatch_busy, bus.drop_err,
             bus.fifo_wdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: busy=%b drop=%b fifo_wdata=%h required all zero",
                     bus.dispatch_busy, bus.drop_err, bus.fifo_wdata);
        end
        drop_model = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ({bus.fifo_push, bus.fifo_wr_done, bus.iram_wr_done, bus.wram_wr_done} != 4'b0)
                seen = 1'b1;
        end
        bus.fifo_full = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        if ({bus.fifo_push, bus.fifo_wr_done, bus.iram_wr_done, bus.wram_wr_done} != 4'b0)
            seen = 1'b1;
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_no_pulse: got pulse=%b required 0", seen);
        end
        data = {$urandom, $urandom};
        run_beat(2'd2, 11'h2C4, data, 64'hFFFF_0000_FFFF_0000, 0, 1'b0, 20, o, to);
        e = predict(2'd2, 11'h2C4, data, 64'hFFFF_0000_FFFF_0000, 0);
        n_cmp++;
        if (to || o !== e) begin
            n_bad++;
            $display("FAIL wram_after_reset: got %s | required %s", fmt(o), fmt(e));
        end
        n_cmp++;
        if (bus.drop_err !== drop_model) begin
            n_bad++;
            $display("FAIL drop_cleared: got %b required %b", bus.drop_err, drop_model);
        end
    endtask

    task automatic test_random();
        beat_t o, e;
        bit    to;
        logic [1:0]    region;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] strb;
        int            fc;
        bit            dbl;
        for (int i = 0; i < 40; i++) begin
            region = 2'($urandom_range(3));
            addr   = AW'($urandom);
            data   = {$urandom, $urandom};
            strb   = ($urandom_range(3) != 0) ? {DW{1'b1}} : {$urandom, $urandom};
            fc     = $urandom_range(5);
            dbl    = ($urandom_range(4) == 0);
            run_beat(region, addr, data, strb, fc, dbl, 40, o, to);
            if (dbl) drop_model = 1'b1;
            e = predict(region, addr, data, strb, fc);
            n_cmp++;
            if (to || o !== e) begin
                n_bad++;
                $display("FAIL rand_beat_%0d r=%0d fc=%0d: got %s | required %s",
                         i, region, fc, fmt(o), fmt(e));
            end
            n_cmp++;
            if (bus.drop_err !== drop_model) begin
                n_bad++;
                $display("FAIL rand_drop_%0d: got %b required %b", i, bus.drop_err, drop_model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_iram();
        test_fifo_backpressure();
        test_errors();
        test_long_wait();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_dispatch.md
AXI_WR_DISPATCH -- requirements
Module: axi_wr_dispatch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning write address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning data width; strobe/mask width equals DATA_WIDTH.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning FIFO-full wait limit; 8-bit range, 1..255.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- axi_wr_vld, in, 1, one-cycle pulse; write beat present.
- axi_wr_addr, in, ADDR_WIDTH, beat address.
- axi_wr_data, in, DATA_WIDTH, beat data.
- axi_wr_strb, in, DATA_WIDTH, per-bit write mask (byte strobe pre-expanded).
- axi_wr_region, in, 2, target: 0 = FIFO, 1 = IRAM, 2 = WRAM, 3 = invalid.
- fifo_wr_done / iram_wr_done / wram_wr_done, out, 1 each, one-cycle completion pulses.
- fifo_err, out, 1, error qualifier, valid only with fifo_wr_done.
- fifo_push, out, 1, FIFO push strobe; fifo_wdata, out, DATA_WIDTH; fifo_full, in, 1.
- iram_we, out, 1; iram_addr, out, ADDR_WIDTH; iram_wdata, out, DATA_WIDTH; iram_wmask, out, DATA_WIDTH.
- wram_we, out, 1; wram_addr, out, ADDR_WIDTH; wram_wdata, out, DATA_WIDTH; wram_wmask, out, DATA_WIDTH.
- dispatch_busy, out, 1, high whenever state is not IDLE.
- drop_err, out, 1, sticky flag: beat arrived while busy.

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, FIFO_WAIT, DONE.
REQ-006 IDLE: on axi_wr_vld, SHALL capture addr/data/strb/region into holding registers and go to ISSUE.
REQ-007 ISSUE, region 1: SHALL assert iram_we for exactly one cycle with held addr/data/mask, then go to DONE. Region 2 behaves identically on the wram_* ports.
REQ-008 ISSUE, region 0 with strb all-ones and fifo_full low: SHALL assert fifo_push for one cycle with fifo_wdata = held data, then go to DONE.
REQ-009 ISSUE, region 0 with fifo_full high: SHALL go to FIFO_WAIT and issue no push. FIFO_WAIT SHALL push in the first cycle fifo_full is low, then go to DONE.
REQ-010 Region 0 with strb not all-ones, or region 3: SHALL issue no write, go to DONE, and flag an error.
REQ-011 DONE: SHALL pulse exactly one done output for one cycle, selected by held region. Region 3 SHALL use fifo_wr_done. SHALL then return to IDLE.
REQ-012 fifo_err SHALL be high in the DONE cycle iff an error was flagged (REQ-010 or REQ-019); otherwise low.
REQ-013 Latency, vld at cycle T, no backpressure: write strobe at T+1, done pulse at T+2. Each FIFO_WAIT cycle adds one cycle.
REQ-014 axi_wr_vld outside IDLE SHALL be ignored and SHALL set drop_err. drop_err clears only on reset.
REQ-015 At most one write strobe and one done pulse SHALL occur per accepted beat. iram_we, wram_we and fifo_push SHALL be mutually exclusive.
REQ-016 *_addr, *_wdata and *_wmask outputs SHALL drive the holding registers continuously; they are meaningful only with the matching strobe.

Reset
REQ-017 rst_n low SHALL immediately force:
- state IDLE;
- all strobes, done pulses, fifo_err, dispatch_busy, drop_err and the wait counter to 0;
- holding registers to 0.
REQ-018 Reset mid-operation SHALL abort the beat with no write and no done pulse. The first beat after release is handled normally.

Configuration
REQ-019 With macro WR_DISPATCH_TIMEOUT_EN defined: SHALL count cycles in FIFO_WAIT with an 8-bit counter. On reaching TIMEOUT_CYCLES, SHALL abandon the push, go to DONE and flag an error. The counter SHALL clear on entry to FIFO_WAIT.
REQ-020 Without WR_DISPATCH_TIMEOUT_EN: no counter logic. FIFO_WAIT SHALL wait indefinitely for fifo_full low.

Verification
REQ-021 Region 1: addr 0x010, data 0xA5A5..A5, mask all-ones -> iram_we at T+1 with addr 0x010; iram_wr_done at T+2; fifo_err 0.
REQ-022 Region 0 with fifo_full high for 3 cycles -> fifo_push in the first cycle fifo_full is low; fifo_wr_done on the next cycle; fifo_err 0.
REQ-023 Region 3, or region 0 with mask 0x00FF..FF -> no strobe at all; fifo_wr_done and fifo_err both 1 at T+2.
REQ-024 Second axi_wr_vld at T+1 -> beat ignored, drop_err 1 and held until reset; first beat completes normally.
REQ-025 rst_n low during FIFO_WAIT -> all outputs 0 immediately, no done pulse; a region 2 beat after release gives wram_wr_done at T+2.
REQ-026 With WR_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES = 4, fifo_full held high -> fifo_wr_done with fifo_err after 4 wait cycles, no push. Without the macro -> waits indefinitely.
